// File: rtl/vga_if.sv
// vga_if: VGA timing bundle shared along the video chain.
//   vblnk : vertical blanking, high during the vertical blank interval.
// Modports: out/master drive the timing, in/slave consume it.
interface vga_if;
  logic vblnk;

  modport out    (output vblnk);
  modport master (output vblnk);
  modport in     (input  vblnk);
  modport slave  (input  vblnk);
endinterface

// File: rtl/animation_ctl.sv
// animation_ctl: startup sequencer for the ladder reveal animation.
// Counts vblank rising edges (frame ticks) and steps `counter` down once
// every FRAMES_PER_STEP frames, so animation_ladder grows the ladders in.
//
// Ports:
//   clk       : pixel clock (65 MHz, VGA domain)
//   rst       : synchronous, active-high reset
//   game_en   : game running; low returns the block to idle
//   start     : one-cycle request to begin the animation
//   skip      : jump straight to completion (only with ANIMATION_CTL_SKIP_EN)
//   in        : VGA timing source, only in.vblnk is used
//   animation : high while the reveal is in progress (registered)
//   counter   : ladders still hidden (registered)
//   done      : one-cycle completion pulse (registered)
//
// Optional feature: define ANIMATION_CTL_SKIP_EN to add the skip input.
module animation_ctl #(
  parameter logic [3:0] COUNTER_START   = 4'd12,
  parameter logic [7:0] FRAMES_PER_STEP = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic       start,
`ifdef ANIMATION_CTL_SKIP_EN
  input  logic       skip,
`endif
  vga_if.in          in,
  output logic       animation,
  output logic [3:0] counter,
  output logic       done
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAMES_PER_STEP - FRAME_W'(1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               animation_q, animation_d;
  logic               done_q, done_d;
  logic               vblnk_q;
  logic               tick;

  // Frame tick on the rising edge of vertical blanking
  assign tick = in.vblnk & ~vblnk_q;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      counter_q   <= COUNTER_START;
      frame_cnt_q <= '0;
      animation_q <= 1'b0;
      done_q      <= 1'b0;
      vblnk_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      frame_cnt_q <= frame_cnt_d;
      animation_q <= animation_d;
      done_q      <= done_d;
      vblnk_q     <= in.vblnk;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        counter_d = COUNTER_START;
        if (start) begin
          state_d     = RUN;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        if (tick) begin
          if (frame_cnt_q == LAST_FRAME) begin
            frame_cnt_d = '0;
            // One extra step at zero before finishing, so the last ladder
            // stays visible for a full step
            if (counter_q != '0) begin
              counter_d = counter_q - CNT_W'(1);
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
`ifdef ANIMATION_CTL_SKIP_EN
        if (skip) begin
          state_d     = DONE;
          counter_d   = '0;
          frame_cnt_d = '0;
          done_d      = 1'b1;
        end
`endif
      end
      DONE: begin
        counter_d = '0;
      end
      default: begin
        state_d   = IDLE;
        counter_d = COUNTER_START;
      end
    endcase

    // Abort overrides everything else, with no completion pulse
    if (!game_en) begin
      state_d     = IDLE;
      counter_d   = COUNTER_START;
      frame_cnt_d = '0;
      done_d      = 1'b0;
    end

    animation_d = (state_d == RUN);
  end

  assign animation = animation_q;
  assign counter   = counter_q;
  assign done      = done_q;

endmodule

// File: tb/tb_animation_ctl.sv
// tb_animation_ctl: directed self-checking bench for animation_ctl.
// A default-parameter instance covers reset values; a small instance
// (COUNTER_START=3, FRAMES_PER_STEP=2) covers the sequencing.
`timescale 1ns/1ps
module tb_animation_ctl;

  logic clk = 1'b0;
  logic rst;
  logic game_en;
  logic start;
`ifdef ANIMATION_CTL_SKIP_EN
  logic skip;
`endif

  logic       anim_d0, done_d0;
  logic [3:0] cnt_d0;
  logic       anim, done;
  logic [3:0] cnt;

  int errors = 0;
  int checks = 0;

  vga_if vga ();

  always #5 clk = ~clk;

  animation_ctl u_dut_def (
    .clk       (clk),
    .rst       (rst),
    .game_en   (game_en),
    .start     (start),
`ifdef ANIMATION_CTL_SKIP_EN
    .skip      (skip),
`endif
    .in        (vga),
    .animation (anim_d0),
    .counter   (cnt_d0),
    .done      (done_d0)
  );

  animation_ctl #(
    .COUNTER_START   (4'd3),
    .FRAMES_PER_STEP (8'd2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .game_en   (game_en),
    .start     (start),
`ifdef ANIMATION_CTL_SKIP_EN
    .skip      (skip),
`endif
    .in        (vga),
    .animation (anim),
    .counter   (cnt),
    .done      (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int e_cnt, input int e_anim,
                           input int e_done);
    check({tag, ".counter"},   int'(cnt),  e_cnt);
    check({tag, ".animation"}, int'(anim), e_anim);
    check({tag, ".done"},      int'(done), e_done);
  endtask

  // One-cycle vblank pulse; checks the cycle after the tick edge
  task automatic tick_check(input string tag, input int e_cnt, input int e_anim,
                            input int e_done);
    vga.vblnk = 1'b1;
    step();
    check_out(tag, e_cnt, e_anim, e_done);
    vga.vblnk = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int e_cnt;
    rst       = 1'b1;
    game_en   = 1'b0;
    start     = 1'b0;
    vga.vblnk = 1'b0;
`ifdef ANIMATION_CTL_SKIP_EN
    skip      = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check("rst_def.animation", int'(anim_d0), 0);
    check("rst_def.counter",   int'(cnt_d0),  12);
    check("rst_def.done",      int'(done_d0), 0);
    check_out("rst_small", 3, 0, 0);

    // Full run, with a redundant start on tick 3
    game_en = 1'b1;
    step();
    check_out("idle", 3, 0, 0);
    do_start();
    check_out("tick0", 3, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      e_cnt = (k >= 6) ? 0 : 3 - k / 2;
      if (k == 3) start = 1'b1;
      tick_check($sformatf("tick%0d", k), e_cnt, (k < 8) ? 1 : 0,
                 (k == 8) ? 1 : 0);
      start = 1'b0;
    end
    check_out("done_end", 0, 0, 0);

    // DONE: start ignored, ticks do not wrap the counter
    do_start();
    check_out("done_start", 0, 0, 0);
    tick_check("done_tick", 0, 0, 0);

    // Abort returns to idle with counter reloaded
    game_en = 1'b0;
    step();
    check_out("leave_done", 3, 0, 0);
    game_en = 1'b1;
    do_start();
    check_out("run2", 3, 1, 0);
    tick_check("run2_t1", 3, 1, 0);
    tick_check("run2_t2", 2, 1, 0);
    tick_check("run2_t3", 2, 1, 0);
    game_en = 1'b0;
    step();
    check_out("abort", 3, 0, 0);
    step();
    check_out("abort_hold", 3, 0, 0);

    // Restart, then long vblank produces only one tick
    game_en = 1'b1;
    do_start();
    check_out("run3", 3, 1, 0);
    tick_check("run3_t1", 3, 1, 0);
    tick_check("run3_t2", 2, 1, 0);
    vga.vblnk = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check_out("long_vblnk", 2, 1, 0);
    vga.vblnk = 1'b0;
    step();
    tick_check("after_long", 1, 1, 0);

    // Reset mid-animation
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("mid_rst", 3, 0, 0);
    step();
    check_out("mid_rst_hold", 3, 0, 0);

`ifdef ANIMATION_CTL_SKIP_EN
    do_start();
    tick_check("skip_t1", 3, 1, 0);
    tick_check("skip_t2", 2, 1, 0);
    skip = 1'b1;
    step();
    skip = 1'b0;
    check_out("skip", 0, 0, 1);
    step();
    check_out("skip_after", 0, 0, 0);
    skip = 1'b1;
    step();
    skip = 1'b0;
    check_out("skip_in_done", 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/animation_ctl.md
# animation_ctl

Sequencer that drives the ladder reveal animation at game startup. It generates the `animation` flag and the 4-bit `counter` consumed by `animation_ladder`: `counter` counts down once every `FRAMES_PER_STEP` video frames, so the ladders grow into view. It sits beside the VGA pipeline, sampling blanking to derive a frame tick, and is owned by the game-control logic.

## Interface
- `COUNTER_START`, 4'd12: `counter` value at animation start; number of ladders hidden.
- `FRAMES_PER_STEP`, 8'd8: frame ticks per `counter` decrement; legal range 1..255.
- `clk` input 1: pixel clock, 65 MHz domain shared with the VGA chain.
- `rst` input 1: synchronous, active-high reset.
- `game_en` input 1: game running; low aborts or returns the block to idle.
- `start` input 1: one-cycle request to begin the animation.
- `in` vga_if.in: timing source; only `in.vblnk` is used.
- `animation` output 1: high while the reveal is in progress.
- `counter` output 4: ladders still hidden; each step reveals 32 px.
- `done` output 1: one-cycle pulse on completion.
- `skip` input 1: present only with `ANIMATION_CTL_SKIP_EN`.

## Operation
- Frame tick: `vblnk_q` registers `in.vblnk`. `tick = in.vblnk & ~vblnk_q`, a rising edge of vblank.
- Reset: state IDLE, `animation`=0, `counter`=`COUNTER_START`, `done`=0, `vblnk_q`=0, `frame_cnt`=0.
- IDLE:
  - `animation`=0, `counter`=`COUNTER_START`.
  - `start & game_en` leads to RUN, with `frame_cnt` cleared.
- RUN:
  - `animation`=1.
  - On each tick, if `frame_cnt`==`FRAMES_PER_STEP`-1, `frame_cnt` is set to 0. Then:
    - if `counter`!=0, `counter` decrements;
    - if `counter`==0, go to DONE and pulse `done`.
  - Otherwise a tick increments `frame_cnt`.
  - Cycles without a tick hold all state.
- DONE:
  - `animation`=0, `counter`=0, `done`=0 after its single pulse.
  - The block holds here until `game_en`=0, then goes to IDLE.
  - `start` is ignored in DONE.
- `game_en`=0 in any state leads to IDLE on the next cycle, with `counter` reloaded and `animation`=0. This has priority over `start`, `tick` and `skip`. No `done` pulse is issued on abort.
- `start` in RUN is ignored; there is no restart.
- `counter` never wraps below 0. `frame_cnt` is 8 bits and never exceeds `FRAMES_PER_STEP`-1.

## Timing
- All outputs are registered.
- `start` high at cycle N: `animation`=1 at N+1.
- Ticks are counted from RUN entry. The decrement to `COUNTER_START`-k happens on tick k·`FRAMES_PER_STEP`.
- On tick (`COUNTER_START`+1)·`FRAMES_PER_STEP`, one cycle after the tick edge:
  - `animation` falls;
  - `done`=1 for exactly one cycle;
  - `counter` is already 0.
- A tick coincident with `start` in IDLE is not counted.
- Reset mid-animation returns the reset values on the next cycle.

## Configuration
- `ANIMATION_CTL_SKIP_EN` defined:
  - The `skip` input exists.
  - `skip`=1 in RUN (with `game_en`=1) leads to DONE next cycle: `counter`=0, `animation`=0, `done` pulses once.
  - `skip` is ignored in IDLE and DONE.
- Not defined: no `skip` port, and the animation always runs its full length.

## Test plan
- Reset: drive `rst` for 2 cycles, then check `animation`=0, `counter`=12 and `done`=0.
- Full run with `COUNTER_START`=3, `FRAMES_PER_STEP`=2 and 1-cycle ticks.
  - After `start`, `counter` is 3, 2, 1, 0 after ticks 0, 2, 4, 6.
  - `animation` falls and `done` pulses once after tick 8.
- Abort: in the same configuration, drop `game_en` after tick 3.
  - Next cycle: IDLE, `counter`=3, `animation`=0, no `done`.
  - A new `start` with `game_en`=1 restarts from 3.
- Ignored inputs:
  - `start` repeated during RUN leaves the count sequence unchanged.
  - `start` in DONE keeps `animation`=0.
- Tick alignment: hold `in.vblnk` high for 100 cycles. This produces exactly 1 tick per rising edge, and `frame_cnt` increments once.
- Skip (`ANIMATION_CTL_SKIP_EN` defined): `skip` pulsed with `counter`=2 in RUN gives `counter`=0, `animation`=0 and a single `done` on the next cycle.
